// File: rtl/key_pulse_pkg.sv
// ---------------------------------------------------------------------------
// key_pulse_pkg
//   Shared definitions for the push-button to direction-pulse front end.
//   - arb_state_t : arbiter / lockout FSM states
//   - DIR_*       : bit index of each direction in the internal 4-bit vectors
//   - DEF_*       : default debounce and lockout lengths in clk cycles
//   - pick_dir    : fixed-priority (U > D > L > R) one-hot select
// ---------------------------------------------------------------------------
package key_pulse_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    localparam int NUM_DIR = 4;
    localparam int DIR_U   = 0;
    localparam int DIR_D   = 1;
    localparam int DIR_L   = 2;
    localparam int DIR_R   = 3;

    localparam int DEF_DEB_CYC  = 1000000;
    localparam int DEF_LOCK_CYC = 4;

    // Keeps only the highest-priority request; the others are simply lost.
    function automatic logic [NUM_DIR-1:0] pick_dir(input logic [NUM_DIR-1:0] req);
        logic [NUM_DIR-1:0] sel;
        sel = '0;
        if (req[DIR_U]) begin
            sel[DIR_U] = 1'b1;
        end else if (req[DIR_D]) begin
            sel[DIR_D] = 1'b1;
        end else if (req[DIR_L]) begin
            sel[DIR_L] = 1'b1;
        end else if (req[DIR_R]) begin
            sel[DIR_R] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// ---------------------------------------------------------------------------
// debounce_cell
//   One push-button channel: 2-flop synchronizer, mismatch counter and
//   debounced level. A new level is accepted only after the synchronized
//   input has disagreed with the current level for DEB_CYC consecutive
//   cycles; any agreement in between restarts the count.
//
//   Ports
//     clk  : system clock, rising edge
//     clr  : asynchronous active-high reset
//     btn  : raw asynchronous button, high = pressed
//     rise : registered one-cycle strobe when the debounced level goes 0->1
// ---------------------------------------------------------------------------
module debounce_cell
    import key_pulse_pkg::*;
#(
    parameter int DEB_CYC = DEF_DEB_CYC
) (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYC);
    localparam logic [CW-1:0] CNT_TC = CW'(DEB_CYC - 1);

    logic [1:0]    sync_q;
    logic          level;
    logic [CW-1:0] cnt;
    logic          sync_val;

    assign sync_val = sync_q[1];

    // The counter tops out at DEB_CYC-1: either the level is accepted there
    // or a match clears it first, so it can never wrap.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q <= '0;
            level  <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            rise   <= 1'b0;
            if (sync_val != level) begin
                if (cnt == CNT_TC) begin
                    level <= sync_val;
                    cnt   <= '0;
                    // Only a new pressed level is an event; release is silent.
                    rise  <= sync_val;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/key_pulse_gen.sv
// ---------------------------------------------------------------------------
// key_pulse_gen
//   Turns four raw direction buttons into registered single-cycle pulses for
//   the move controller. Each button is debounced by its own debounce_cell;
//   a small arbiter accepts one press at a time (U > D > L > R) and then
//   ignores all presses for LOCK_CYC cycles, counting the pulse cycle.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | waiting for a debounced press event
//   ST_LOCK | pulse issued; lock_cnt counts down the remaining lockout cycles
//
//   Ports
//     clk                         : system clock, rising edge
//     clr                         : asynchronous active-high reset
//     btn_u, btn_d, btn_l, btn_r  : raw asynchronous buttons, high = pressed
//     U, D, L, R                  : registered, mutually exclusive 1-cycle pulses
// ---------------------------------------------------------------------------
module key_pulse_gen
    import key_pulse_pkg::*;
#(
    parameter int DEB_CYC  = DEF_DEB_CYC,
    parameter int LOCK_CYC = DEF_LOCK_CYC
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_u,
    input  logic btn_d,
    input  logic btn_l,
    input  logic btn_r,
    output logic U,
    output logic D,
    output logic L,
    output logic R
);

    localparam int LW = $clog2(LOCK_CYC);
    // Loaded on the pulse edge so that lock_cnt reads 0 in the last lockout
    // cycle; the FSM leaves LOCK on that cycle's closing edge.
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYC - 1);

    logic [NUM_DIR-1:0] btn_vec;
    logic [NUM_DIR-1:0] press_ev;

    arb_state_t         state, state_nxt;
    logic [LW-1:0]      lock_cnt, lock_cnt_nxt;
    logic [NUM_DIR-1:0] pulse_q, pulse_nxt;

    always_comb begin
        btn_vec        = '0;
        btn_vec[DIR_U] = btn_u;
        btn_vec[DIR_D] = btn_d;
        btn_vec[DIR_L] = btn_l;
        btn_vec[DIR_R] = btn_r;
    end

    for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_deb
        debounce_cell #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clk  (clk),
            .clr  (clr),
            .btn  (btn_vec[gi]),
            .rise (press_ev[gi])
        );
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= ST_IDLE;
            lock_cnt <= '0;
            pulse_q  <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            pulse_q  <= pulse_nxt;
        end
    end

    // Press events are single-cycle strobes, so anything not taken in the
    // cycle it appears is dropped for good and a held button cannot re-fire.
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        pulse_nxt    = '0;
        case (state)
            ST_IDLE: begin
                if (|press_ev) begin
                    pulse_nxt    = pick_dir(press_ev);
                    lock_cnt_nxt = LOCK_LOAD;
                    state_nxt    = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (lock_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    lock_cnt_nxt = lock_cnt - LW'(1);
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    assign U = pulse_q[DIR_U];
    assign D = pulse_q[DIR_D];
    assign L = pulse_q[DIR_L];
    assign R = pulse_q[DIR_R];

endmodule

// File: tb/tb_key_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_key_pulse_gen
//   Bench for key_pulse_gen with DEB_CYC=4, LOCK_CYC=4. A behavioural model
//   (delay line, run-length debounce, remaining-lockout counter) predicts the
//   outputs every cycle; directed scenarios add fixed expected pulse edges.
//   Output bit order in this bench: [0]=U [1]=D [2]=L [3]=R.
// ---------------------------------------------------------------------------
module tb_key_pulse_gen;

    localparam int DEB = 4;
    localparam int LCK = 4;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic btn_u = 1'b0;
    logic btn_d = 1'b0;
    logic btn_l = 1'b0;
    logic btn_r = 1'b0;
    logic U, D, L, R;

    int n_chk  = 0;
    int n_fail = 0;

    key_pulse_gen #(
        .DEB_CYC  (DEB),
        .LOCK_CYC (LCK)
    ) dut (
        .clk   (clk),
        .clr   (clr),
        .btn_u (btn_u),
        .btn_d (btn_d),
        .btn_l (btn_l),
        .btn_r (btn_r),
        .U     (U),
        .D     (D),
        .L     (L),
        .R     (R)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] raw_d1, raw_d2;   // raw samples one and two edges old
    logic [3:0] lvl_m;            // accepted button levels
    int         run_m [4];        // consecutive edges the synced value disagreed
    logic [3:0] ev_m;             // press events visible to the next edge
    int         busy_m;           // lockout cycles still to go, incl. current
    logic [3:0] out_m;

    task automatic model_reset();
        raw_d1 = '0;
        raw_d2 = '0;
        lvl_m  = '0;
        ev_m   = '0;
        out_m  = '0;
        busy_m = 0;
        for (int b = 0; b < 4; b++) run_m[b] = 0;
    endtask

    task automatic model_step();
        logic [3:0] nxt_out;
        logic [3:0] nxt_ev;
        logic [3:0] raw;
        if (clr) begin
            model_reset();
            return;
        end
        raw     = {btn_r, btn_l, btn_d, btn_u};
        nxt_out = '0;
        if (busy_m > 0) begin
            busy_m--;
        end else if (ev_m != 4'b0) begin
            for (int b = 0; b < 4; b++) begin
                if (ev_m[b] && nxt_out == 4'b0) nxt_out[b] = 1'b1;
            end
            busy_m = LCK;
        end
        nxt_ev = '0;
        for (int b = 0; b < 4; b++) begin
            if (raw_d2[b] != lvl_m[b]) begin
                run_m[b]++;
                if (run_m[b] == DEB) begin
                    lvl_m[b] = raw_d2[b];
                    run_m[b] = 0;
                    nxt_ev[b] = raw_d2[b];
                end
            end else begin
                run_m[b] = 0;
            end
        end
        raw_d2 = raw_d1;
        raw_d1 = raw;
        out_m  = nxt_out;
        ev_m   = nxt_ev;
    endtask

    // ---------------- cycle driver ----------------
    int edge_n = 0;
    int base   = 0;
    int n_pulse    [4];
    int first_edge [4];

    task automatic clear_stats();
        base = edge_n;
        for (int b = 0; b < 4; b++) begin
            n_pulse[b]    = 0;
            first_edge[b] = -1;
        end
    endtask

    task automatic tick();
        logic [3:0] outs;
        @(posedge clk);
        model_step();
        edge_n++;
        @(negedge clk);
        outs = {R, L, D, U};
        check_val("out_vs_model", {28'b0, outs}, {28'b0, out_m});
        check_val("onehot", {31'b0, ($countones(outs) <= 1)}, 32'd1);
        for (int b = 0; b < 4; b++) begin
            if (outs[b] === 1'b1) begin
                n_pulse[b]++;
                if (first_edge[b] < 0) first_edge[b] = edge_n - base;
            end
        end
    endtask

    task automatic set_btns(input logic [3:0] v);
        btn_u = v[0];
        btn_d = v[1];
        btn_l = v[2];
        btn_r = v[3];
    endtask

    // Button b is high for the edges st..st+len-1 of the scenario (st=0: never).
    int sc_st  [4];
    int sc_len [4];

    task automatic run_scen(input int n_edges);
        logic [3:0] v;
        set_btns(4'b0);
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        clear_stats();
        for (int k = 1; k <= n_edges; k++) begin
            for (int b = 0; b < 4; b++)
                v[b] = (sc_st[b] != 0) && (k >= sc_st[b]) && (k < sc_st[b] + sc_len[b]);
            set_btns(v);
            tick();
        end
        set_btns(4'b0);
    endtask

    task automatic set_scen(input int su, lu, sd, ld, sl, ll, sr, lr);
        sc_st[0] = su; sc_len[0] = lu;
        sc_st[1] = sd; sc_len[1] = ld;
        sc_st[2] = sl; sc_len[2] = ll;
        sc_st[3] = sr; sc_len[3] = lr;
    endtask

    int         hold [4];
    logic [3:0] cur;
    int         clr_left;

    initial begin
        model_reset();
        #2 clr = 1'b1;
        #1 check_val("rst_out", {28'b0, R, L, D, U}, 32'd0);
        tick();

        // Clean press on U, released after 20 cycles.
        set_scen(1, 20, 0, 0, 0, 0, 0, 0);
        run_scen(35);
        check_val("clean_u_edge", first_edge[0], 32'd7);
        check_val("clean_u_cnt", n_pulse[0], 32'd1);
        check_val("clean_other", n_pulse[1] + n_pulse[2] + n_pulse[3], 32'd0);

        // 3-cycle glitch on L.
        set_scen(0, 0, 0, 0, 1, 3, 0, 0);
        run_scen(20);
        check_val("glitch_cnt", n_pulse[0] + n_pulse[1] + n_pulse[2] + n_pulse[3], 32'd0);

        // U and R together, held.
        set_scen(1, 30, 0, 0, 0, 0, 1, 30);
        run_scen(40);
        check_val("simul_u_edge", first_edge[0], 32'd7);
        check_val("simul_u_cnt", n_pulse[0], 32'd1);
        check_val("simul_r_cnt", n_pulse[3], 32'd0);

        // D pulse at T=7; L event in last lock cycle T+3 is dropped.
        set_scen(0, 0, 1, 30, 5, 30, 0, 0);
        run_scen(40);
        check_val("lock_d_edge", first_edge[1], 32'd7);
        check_val("lock_l_drop", n_pulse[2], 32'd0);

        // L event in first idle cycle T+4 is accepted, pulse at T+5.
        set_scen(0, 0, 1, 30, 6, 30, 0, 0);
        run_scen(40);
        check_val("idle_d_edge", first_edge[1], 32'd7);
        check_val("idle_l_edge", first_edge[2], 32'd12);
        check_val("idle_l_cnt", n_pulse[2], 32'd1);

        // Reset after R has been high 3 cycles; R kept held.
        set_btns(4'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        clear_stats();
        btn_r = 1'b1;
        tick();
        tick();
        tick();
        clr = 1'b1;
        #1 check_val("clr_out", {28'b0, R, L, D, U}, 32'd0);
        tick();
        tick();
        clr = 1'b0;
        clear_stats();
        for (int k = 0; k < 15; k++) tick();
        check_val("rst_r_edge", first_edge[3], 32'd7);
        check_val("rst_r_cnt", n_pulse[3], 32'd1);
        btn_r = 1'b0;

        // Random buttons and occasional resets, checked against the model.
        cur = '0;
        clr_left = 0;
        for (int b = 0; b < 4; b++) hold[b] = $urandom_range(1, 10);
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    cur[b]  = ~cur[b];
                    hold[b] = cur[b] ? $urandom_range(1, 12) : $urandom_range(1, 15);
                end
                hold[b]--;
            end
            set_btns(cur);
            if (clr_left > 0) clr_left--;
            else if ($urandom_range(0, 249) == 0) clr_left = $urandom_range(1, 3);
            clr = (clr_left > 0);
            tick();
        end
        clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_pulse_gen.md
KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 Parameter DEB_CYC, default 1000000: consecutive clk cycles a synchronized button must hold a new level before that level is accepted (minimum 2).
REQ-002 Parameter LOCK_CYC, default 4: cycles, counting the pulse cycle, during which new presses are ignored after a pulse (minimum 3).
REQ-003 Port clk, input, 1: system clock, rising-edge active.
REQ-004 Port clr, input, 1: reset, asynchronous, active-high.
REQ-005 Ports btn_u, btn_d, btn_l, btn_r, input, 1 each: raw asynchronous push-buttons, high = pressed.
REQ-006 Ports U, D, L, R, input-side of the move controller, output, 1 each: registered single-cycle direction-press pulses.

Function
REQ-007 Each btn_* SHALL pass through a 2-flop synchronizer before any other logic.
REQ-008 Each button SHALL have a debounced level register and a counter; the counter SHALL increment while the synchronized value differs from the debounced level and SHALL clear to 0 when they match.
REQ-009 When the counter equals DEB_CYC-1 and a mismatch is still present, the debounced level SHALL take the synchronized value and the counter SHALL clear.
REQ-010 A mismatch lasting fewer than DEB_CYC consecutive cycles SHALL leave the debounced level unchanged.
REQ-011 A 0->1 transition of a debounced level SHALL be a press event; a 1->0 transition SHALL generate nothing.
REQ-012 Arbiter FSM states: IDLE, LOCK.
REQ-013 In IDLE, on one or more press events, the block SHALL register exactly one pulse with priority U > D > L > R and SHALL enter LOCK.
REQ-014 Lower-priority press events in the same cycle SHALL be dropped, not queued, and SHALL not re-fire while that button stays held.
REQ-015 In LOCK, all press events SHALL be dropped; after LOCK_CYC cycles, including the pulse cycle, the FSM SHALL return to IDLE.
REQ-016 A press event in the last LOCK cycle SHALL be dropped; a press event in the first IDLE cycle SHALL be accepted.
REQ-017 U, D, L, R SHALL be mutually exclusive, and each pulse SHALL be high for exactly one cycle.
REQ-018 Latency: the pulse SHALL be high after rising edge DEB_CYC+3, where edge 1 is the first edge that samples the raw button high, provided the button is stable and the FSM is in IDLE.
REQ-019 Holding a button indefinitely SHALL yield one pulse only; there is no auto-repeat.

Reset
REQ-020 While clr is high, all of the following SHALL be 0 immediately: synchronizers, debounced levels, counters, the lock counter, and U/D/L/R; the FSM SHALL be in IDLE.
REQ-021 Asserting clr mid-debounce or mid-lock SHALL discard all progress.
REQ-022 A button held through clr deassertion SHALL produce one pulse after a full fresh debounce.

Structure
REQ-023 Shared package key_pulse_pkg SHALL hold the FSM state enum, the direction index constants (U=0, D=1, L=2, R=3) and the default DEB_CYC/LOCK_CYC values.
REQ-024 Sub-module debounce_cell (synchronizer + counter + level + rise-event output) SHALL be instantiated four times; the arbiter/lock FSM SHALL live in key_pulse_gen.
REQ-025 Counter widths SHALL be $clog2 of their parameter, and the counters SHALL never wrap.

Verification (DEB_CYC=4, LOCK_CYC=4)
REQ-026 Clean press: btn_u high for 20 cycles, then low -> U=1 only after edge 7, one cycle; no pulse on release; D/L/R stay 0.
REQ-027 Glitch: btn_l high for 3 cycles, then low -> no pulse ever.
REQ-028 Simultaneous press: btn_u and btn_r rise on the same cycle and are held -> a single U pulse; R never pulses.
REQ-029 Lockout boundary:
- btn_d press -> D pulse at cycle T.
- btn_l debounced press event at T+3 -> dropped.
- Fresh btn_l press event at T+4 -> L pulse at T+5.
REQ-030 Reset mid-debounce: clr pulsed while btn_r has been high 3 cycles, btn_r held -> outputs 0 during clr; R pulse 7 edges after clr deasserts.
